// File: rtl/multi_bit_change_monitor_pkg.sv
// Shared types and constants for the multi-bit change monitor.
// Mode encodings and the counter saturation helper used by every channel.
package multi_bit_change_monitor_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // Largest value an unsigned counter of cnt_w bits can hold (cnt_w <= 31).
    function automatic int unsigned sat_value(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/change_monitor_chan.sv
// One monitored channel: input synchroniser, edge qualifier, saturating event
// counter with sticky and saturation flags.
module change_monitor_chan
    import multi_bit_change_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  mode_t            mode,
    input  logic             clr,
    output logic             out_bit,
    output logic             qual_edge,
    output logic             pulse,
    output logic [CNT_W-1:0] cnt,
    output logic             sticky,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sticky_q, sticky_d;
    logic                   sat_q, sat_d;
    logic                   rise, fall;

    if (SYNC_STAGES == 1) begin : g_sync_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sync_q <= '0;
            else     sync_q <= in_bit;
        end
    end else begin : g_sync_multi
        always_ff @(posedge clk or posedge rst) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign out_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        rise      = out_bit & ~prev_q;
        fall      = ~out_bit & prev_q;
        qual_edge = 1'b0;
        unique case (mode)
            MODE_OFF:  qual_edge = 1'b0;
            MODE_RISE: qual_edge = rise;
            MODE_FALL: qual_edge = fall;
            MODE_BOTH: qual_edge = rise | fall;
        endcase

        // Clear is applied before a coincident event, so that event still counts once.
        cnt_d    = clr ? '0   : cnt_q;
        sticky_d = clr ? 1'b0 : sticky_q;
        sat_d    = clr ? 1'b0 : sat_q;
        if (qual_edge) begin
            sticky_d = 1'b1;
            if (cnt_d == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            prev_q   <= out_bit;
            pulse_q  <= qual_edge;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            sat_q    <= sat_d;
        end
    end

    assign pulse  = pulse_q;
    assign cnt    = cnt_q;
    assign sticky = sticky_q;
    assign sat    = sat_q;

endmodule

// File: rtl/multi_bit_change_monitor.sv
// WIDTH independent change-monitor channels sharing one mode and clear,
// plus a registered OR of all channel pulses.
module multi_bit_change_monitor
    import multi_bit_change_monitor_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_bits,
    input  mode_t                  mode,
    input  logic                   clr,
    output logic [WIDTH-1:0]       out_bits,
    output logic [WIDTH-1:0]       change_pulse,
    output logic [WIDTH*CNT_W-1:0] change_cnt,
    output logic [WIDTH-1:0]       sticky,
    output logic [WIDTH-1:0]       cnt_sat,
    output logic                   any_change
);

    logic [WIDTH-1:0] qual_edges;
    logic             any_change_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        change_monitor_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .in_bit    (in_bits[i]),
            .mode      (mode),
            .clr       (clr),
            .out_bit   (out_bits[i]),
            .qual_edge (qual_edges[i]),
            .pulse     (change_pulse[i]),
            .cnt       (change_cnt[i*CNT_W +: CNT_W]),
            .sticky    (sticky[i]),
            .sat       (cnt_sat[i])
        );
    end

    // Registered from the same qualified edges so it lines up with change_pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_change_q <= 1'b0;
        else     any_change_q <= |qual_edges;
    end

    assign any_change = any_change_q;

endmodule

// File: tb/tb_multi_bit_change_monitor.sv
// Bench for multi_bit_change_monitor (WIDTH=4, CNT_W=3, SYNC_STAGES=2): a reference
// model feeds a scoreboard every cycle, plus table-driven and hand-written checks.
module tb_multi_bit_change_monitor;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [W-1:0]  in_bits;
    logic [1:0]    mode;
    logic [W-1:0]  out_bits, change_pulse, sticky, cnt_sat;
    logic [W*CW-1:0] change_cnt;
    logic          any_change;

    multi_bit_change_monitor #(
        .WIDTH       (W),
        .CNT_W       (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_bits      (in_bits),
        .mode         (mode),
        .clr          (clr),
        .out_bits     (out_bits),
        .change_pulse (change_pulse),
        .change_cnt   (change_cnt),
        .sticky       (sticky),
        .cnt_sat      (cnt_sat),
        .any_change   (any_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]    outb;
        logic [W-1:0]    pulse;
        logic [W*CW-1:0] cnt;
        logic [W-1:0]    stk;
        logic [W-1:0]    sat;
        logic            any;
    } obs_t;

    typedef struct packed {
        logic [3:0] in;
        logic [1:0] md;
        logic       c;
        logic [3:0] exp_out;
        logic [3:0] exp_pulse;
        logic       exp_any;
        logic [3:0] exp_sticky;
        logic [2:0] exp_cnt0;
    } vec_t;

    obs_t   exp_q[$];
    vec_t   vecs[4];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     pulse_seen[W];
    int     any_seen;
    logic [W-1:0] cur;

    // Reference model state
    logic [W-1:0] m_s1, m_out, m_prev, m_pulse, m_sticky, m_sat;
    logic         m_any;
    int           m_cnt[W];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.outb  = out_bits;
        o.pulse = change_pulse;
        o.cnt   = change_cnt;
        o.stk   = sticky;
        o.sat   = cnt_sat;
        o.any   = any_change;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.outb  = m_out;
        o.pulse = m_pulse;
        for (int i = 0; i < W; i++) o.cnt[i*CW +: CW] = 3'(m_cnt[i]);
        o.stk   = m_sticky;
        o.sat   = m_sat;
        o.any   = m_any;
        return o;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_out = '0; m_prev = '0; m_pulse = '0;
        m_sticky = '0; m_sat = '0; m_any = 1'b0;
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
    endtask

    // State after the coming rising edge, given the inputs held across it.
    task automatic model_step(input logic [W-1:0] i_in, input logic [1:0] md, input logic c);
        logic [W-1:0] e;
        if (rst) begin
            model_reset();
            return;
        end
        e = ((m_out & ~m_prev) & {W{md[0]}}) | ((~m_out & m_prev) & {W{md[1]}});
        for (int i = 0; i < W; i++) begin
            if (c) begin
                m_cnt[i] = 0;
                m_sticky[i] = 1'b0;
                m_sat[i] = 1'b0;
            end
            if (e[i]) begin
                m_sticky[i] = 1'b1;
                if (m_cnt[i] == 7) m_sat[i] = 1'b1;
                else               m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_pulse = e;
        m_any   = |e;
        m_prev  = m_out;
        m_out   = m_s1;
        m_s1    = i_in;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < W; i++) pulse_seen[i] = 0;
        any_seen = 0;
    endtask

    // Drive one cycle of inputs, push the model's prediction, compare after the edge.
    task automatic tick(input logic [W-1:0] i_in, input logic [1:0] md, input logic c);
        obs_t want;
        in_bits = i_in;
        mode    = md;
        clr     = c;
        model_step(i_in, md, c);
        exp_q.push_back(model_obs());
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check("scoreboard", 64'(dut_obs()), 64'(want));
        for (int i = 0; i < W; i++) if (change_pulse[i]) pulse_seen[i]++;
        if (any_change) any_seen++;
    endtask

    function automatic logic [2:0] cnt_of(input int ch);
        return change_cnt[ch*CW +: CW];
    endfunction

    initial begin
        rst = 1'b1; clr = 1'b0; in_bits = '0; mode = 2'b11; cur = '0;
        model_reset();
        clear_counts();

        // Reset and latency table
        repeat (3) tick(4'b0000, 2'b11, 1'b0);
        check("reset_state", 64'(dut_obs()), 64'(0));
        #2 rst = 1'b0;

        vecs[0] = '{4'b0001, 2'b11, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd0};
        vecs[1] = '{4'b0001, 2'b11, 1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0000, 3'd0};
        vecs[2] = '{4'b0001, 2'b11, 1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 3'd1};
        vecs[3] = '{4'b0001, 2'b11, 1'b0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 3'd1};
        for (int v = 0; v < 4; v++) begin
            tick(vecs[v].in, vecs[v].md, vecs[v].c);
            check("lat_out",    64'(out_bits),     64'(vecs[v].exp_out));
            check("lat_pulse",  64'(change_pulse), 64'(vecs[v].exp_pulse));
            check("lat_any",    64'(any_change),   64'(vecs[v].exp_any));
            check("lat_sticky", 64'(sticky),       64'(vecs[v].exp_sticky));
            check("lat_cnt0",   64'(cnt_of(0)),    64'(vecs[v].exp_cnt0));
        end
        cur = 4'b0001;

        // Mode filtering on channel 1: rise, fall, off
        for (int r = 0; r < 3; r++) begin
            logic [1:0] md;
            md = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00;
            cur[1] = 1'b0;
            repeat (4) tick(cur, 2'b00, 1'b0);
            clear_counts();
            for (int t = 0; t < 3; t++) begin
                cur[1] = (t != 1);
                repeat (4) tick(cur, md, 1'b0);
            end
            case (r)
                0: begin
                    check("rise_pulses", 64'(pulse_seen[1]), 64'(2));
                    check("rise_cnt1",   64'(cnt_of(1)),     64'(2));
                end
                1: begin
                    check("fall_pulses", 64'(pulse_seen[1]), 64'(1));
                    check("fall_cnt1",   64'(cnt_of(1)),     64'(3));
                end
                default: begin
                    check("off_pulses", 64'(pulse_seen[1]), 64'(0));
                    check("off_cnt1",   64'(cnt_of(1)),     64'(3));
                    check("off_track",  64'(out_bits[1]),   64'(1));
                end
            endcase
        end

        // Saturation on channel 2
        clear_counts();
        for (int k = 0; k < 9; k++) begin
            cur[2] = ~cur[2];
            tick(cur, 2'b11, 1'b0);
        end
        repeat (2) tick(cur, 2'b11, 1'b0);
        check("sat_pulses", 64'(pulse_seen[2]), 64'(9));
        check("sat_cnt2",   64'(cnt_of(2)),     64'(7));
        check("sat_flag2",  64'(cnt_sat[2]),    64'(1));
        clear_counts();
        cur[2] = ~cur[2];
        repeat (3) tick(cur, 2'b11, 1'b0);
        check("sat_more_pulse", 64'(pulse_seen[2]), 64'(1));
        check("sat_hold_cnt2",  64'(cnt_of(2)),     64'(7));

        // Clear colliding with a qualifying edge on channel 3
        for (int k = 0; k < 5; k++) begin
            cur[3] = ~cur[3];
            repeat (2) tick(cur, 2'b11, 1'b0);
        end
        repeat (2) tick(cur, 2'b11, 1'b0);
        check("pre_clr_cnt3", 64'(cnt_of(3)), 64'(5));
        cur[3] = ~cur[3];
        tick(cur, 2'b11, 1'b0);
        tick(cur, 2'b11, 1'b0);
        tick(cur, 2'b11, 1'b1);
        check("coll_cnt3",    64'(cnt_of(3)),       64'(1));
        check("coll_sticky3", 64'(sticky[3]),       64'(1));
        check("coll_sat3",    64'(cnt_sat[3]),      64'(0));
        check("coll_pulse3",  64'(change_pulse[3]), 64'(1));
        tick(cur, 2'b11, 1'b0);
        tick(cur, 2'b11, 1'b1);
        check("clr_only_cnt3",    64'(cnt_of(3)), 64'(0));
        check("clr_only_sticky3", 64'(sticky[3]), 64'(0));
        check("clr_only_sat",     64'(cnt_sat),   64'(0));

        // Simultaneous rising edges on every channel
        cur = 4'b0000;
        repeat (4) tick(cur, 2'b00, 1'b0);
        clear_counts();
        cur = 4'b1111;
        repeat (3) tick(cur, 2'b11, 1'b0);
        check("simul_pulse", 64'(change_pulse), 64'(4'b1111));
        check("simul_any",   64'(any_change),   64'(1));
        repeat (3) tick(cur, 2'b11, 1'b0);
        check("simul_any_once", 64'(any_seen),   64'(1));
        check("simul_cnts",     64'(change_cnt), 64'(12'h249));

        // Reset asserted mid-operation
        cur = 4'b0000;
        tick(cur, 2'b11, 1'b0);
        #2 rst = 1'b1;
        #1 check("midrst_outputs", 64'(dut_obs()), 64'(0));
        repeat (2) tick(cur, 2'b11, 1'b0);
        #1 rst = 1'b0;
        clear_counts();
        repeat (6) tick(cur, 2'b11, 1'b0);
        check("midrst_no_pulse", 64'(pulse_seen[0] + pulse_seen[1] + pulse_seen[2] +
                                     pulse_seen[3]), 64'(0));
        check("midrst_out", 64'(out_bits), 64'(0));

        // Release with an input already high counts as a rising edge
        rst = 1'b1;
        cur = 4'b0010;
        repeat (2) tick(cur, 2'b11, 1'b0);
        #1 rst = 1'b0;
        repeat (3) tick(cur, 2'b11, 1'b0);
        check("rel_high_pulse", 64'(change_pulse), 64'(4'b0010));
        check("rel_high_cnt1",  64'(cnt_of(1)),    64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_bit_change_monitor.md
Name: multi_bit_change_monitor

Overview:
- Parametrised successor to the single-bit registered pass-through sub-block.
- Synchronises a WIDTH-bit input bus and presents it as a delayed registered copy.
- Per channel, detects qualifying transitions (rise, fall or both), emits one-cycle pulses, keeps saturating event counters and sticky flags.
- Sits between testbench/top-level stimulus and downstream logic; it is also the coverage target for toggle and counter-saturation analysis.

Parameters:
- WIDTH, 8, number of independent channels.
- CNT_W, 8, width of each per-channel event counter.
- SYNC_STAGES, 2, synchroniser depth; legal values are 1 to 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_bits  input  WIDTH  raw channel inputs.
- mode  input  2  edge qualifier, global to all channels: 00 off, 01 rise, 10 fall, 11 both.
- clr  input  1  synchronous clear of counters, sticky flags and saturation flags; sampled each cycle.
- out_bits  output  WIDTH  synchronised copy of in_bits.
- change_pulse  output  WIDTH  one-cycle pulse per qualifying edge.
- change_cnt  output  WIDTH*CNT_W  per-channel counters; channel i occupies bits [i*CNT_W +: CNT_W].
- sticky  output  WIDTH  set on a qualifying edge; held until clr.
- cnt_sat  output  WIDTH  set when a counter is at its maximum and another qualifying edge arrives.
- any_change  output  1  OR of change_pulse, registered together with it.

Behaviour:
- Reset: all synchroniser stages, out_bits, previous-value registers, change_pulse, change_cnt, sticky, cnt_sat and any_change go to 0 immediately. Reset asserted mid-operation discards in-flight events with no partial count.
- Synchroniser: in_bits is captured into stage 1 at edge n. out_bits reflects it after edge n+SYNC_STAGES-1. With SYNC_STAGES=1, out_bits is a single register.
- Edge detect: prev register holds out_bits delayed by one cycle.
  - rise = out_bits & ~prev
  - fall = ~out_bits & prev
  - qualifying edge = (rise & mode[0]) | (fall & mode[1])
- Latency: change_pulse, counter increment, sticky and any_change update at edge n+SYNC_STAGES, i.e. one cycle after out_bits changes.
- Pulse width: change_pulse is high for exactly one cycle per edge. Toggling every cycle produces a continuous pulse train in mode 11.
- Counter arithmetic: unsigned, increments by 1 per qualifying edge, saturates at 2^CNT_W-1 with no wrap. A qualifying edge at saturation sets cnt_sat; the counter holds.
- clr with no event: counter, sticky and cnt_sat go to 0 at the next edge.
- clr with a simultaneous qualifying edge: the clear applies first, then the event. Result: counter=1, sticky=1, cnt_sat=0, and change_pulse still fires.
- Mode changes take effect for the edge computed in the same cycle; there is no retroactive counting. mode=00 suppresses pulses and counts but out_bits still tracks the input.
- Reset release with an input held high is seen as a rising edge SYNC_STAGES cycles later and counts as an event.
- Channels are fully independent. Simultaneous edges on several channels each count once; any_change is a single pulse.

Decomposition:
- Package multi_bit_change_monitor_pkg holds:
  - mode localparams MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH;
  - the 2-bit mode typedef;
  - a function returning the saturation value for a given CNT_W.
- Sub-module change_monitor_chan implements one channel: synchroniser, prev register, qualifier, counter, sticky and sat flags. The top instantiates it WIDTH times in a generate loop and ORs the pulses for any_change.

Test Plan (WIDTH=4, CNT_W=3, SYNC_STAGES=2):
- Reset latency: hold rst for 3 cycles, mode=11, in_bits=0000, then set in_bits[0]=1 at edge 0. Required: out_bits[0]=1 after edge 1; change_pulse[0]=1 for one cycle after edge 2; change_cnt[0]=1; sticky[0]=1; any_change=1.
- Mode filtering: mode=01, toggle in_bits[1] 0→1→0→1 with 4-cycle spacing. Required: 2 pulses and change_cnt[1]=2. Repeat with mode=10: 1 pulse. Repeat with mode=00: 0 pulses and out_bits still tracks the input.
- Saturation: mode=11, toggle in_bits[2] nine times. Required: counter stops at 7 and cnt_sat[2]=1. A further edge keeps the counter at 7 and still pulses.
- Clear collision: with change_cnt[3]=5, assert clr in the same cycle the qualifying edge is evaluated. Required: change_cnt[3]=1, sticky[3]=1, cnt_sat[3]=0. clr alone afterwards gives 0/0/0.
- Simultaneous channels: mode=11, in_bits 0000→1111. Required: change_pulse=1111, any_change high for exactly one cycle, every counter incremented by 1.
- Mid-operation reset: assert rst one cycle after in_bits[0] changes. Required: all outputs 0 immediately and no pulse after release while the input is stable low.
